tcam_rule_writer: RTL and testbench
===================================

# tcam_rule_writer

Rule-programming engine for the SRAM-emulated TCAM search array. It accepts one ternary rule per request: a rule index, a 144-bit value, a 144-bit care mask and an opcode. It converts the rule into per-column bit writes for the 72 two-bit-addressed, 4-entry x 256-bit SRAM sub-blocks whose ANDed outputs form the 256-bit match vector. It sits between the control/host interface and the write ports of the search array, and is the write-side counterpart of the lookup path.

## Interface

Parameters:
- KEY_W, 144: search key width in bits; must be even. Number of sub-blocks BLKS = KEY_W/2.
- NUM_RULES, 256: rule count, equal to the SRAM row width and the match-vector width.
- IDX_W, 8: rule index width, clog2(NUM_RULES).
- BLK_W, 7: sub-block index width, clog2(BLKS).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- req_valid, input, 1: request present.
- req_ready, output, 1: engine can accept a request.
- req_op, input, 1: 0 = program rule, 1 = delete rule (column cleared).
- req_idx, input, IDX_W: rule/column index, 0..NUM_RULES-1.
- req_value, input, KEY_W: rule value bits.
- req_mask, input, KEY_W: care mask; 1 = compare, 0 = don't care.
- upd_we, output, 1: write strobe to the search array.
- upd_blk, output, BLK_W: target sub-block, 0..BLKS-1.
- upd_col, output, IDX_W: target column, which is the rule index.
- upd_bits, output, 4: bit written to column upd_col of entry a in sub-block upd_blk is upd_bits[a], for a = 0..3.
- done, output, 1: one-cycle pulse when a request has fully completed.

## Operation

- Handshake: a request is accepted in a cycle where req_valid && req_ready. On acceptance, req_op, req_idx, req_value and req_mask are latched internally. Inputs are don't-care at all other times.
- States:
  - IDLE: req_ready = 1. On acceptance, move to WRITE with blk_cnt = 0.
  - WRITE: req_ready = 0. upd_we = 1 every cycle and blk_cnt increments. When blk_cnt = BLKS-1, move to DONE.
  - DONE: req_ready = 0, done = 1 for exactly one cycle, then return to IDLE.
- Per-block bit computation for sub-block b, with v = value[2b+1:2b] and m = mask[2b+1:2b]:
  - Program (req_op = 0): upd_bits[a] = (((a ^ v) & m) == 2'b00) for each a in 0..3.
  - Delete (req_op = 1): upd_bits = 4'b0000 for every block.
- Encoding examples:
  - m = 00 gives 4'b1111.
  - m = 11, v = 10 gives 4'b0100.
  - m = 10, v = 1x gives 4'b1100.
  - m = 01, v = x1 gives 4'b1010.
- Write ordering: upd_blk runs 0, 1, …, BLKS-1 in strictly ascending order with no gaps or repeats. upd_col is constant for the whole request.
- Only column upd_col of the target sub-block may change. The array performs the bit-write; this block issues no read-modify-write.
- Requests are never queued. Back-to-back requests are serialised through IDLE.
- Reset mid-operation: the engine returns to IDLE immediately and the remaining blocks are not written. The partially written column is undefined to the host, which must reissue the request. No done pulse is produced for an aborted request.

## Timing

- All outputs are registered.
- Reset values: req_ready = 1, upd_we = 0, upd_blk = 0, upd_col = 0, upd_bits = 0, done = 0, state = IDLE.
- Acceptance occurs on the edge ending cycle N.
- Writes:
  - upd_we is high in cycles N+1 .. N+BLKS (72 cycles).
  - Block k is written in cycle N+1+k.
- Completion:
  - done is high in cycle N+BLKS+1.
  - req_ready returns high in cycle N+BLKS+2.
- Maximum throughput is one rule per BLKS+2 = 74 cycles.
- When upd_we = 0, upd_blk, upd_col and upd_bits hold their previous values; the array must ignore them.
- If rst and req_valid are both high in the same cycle, reset wins and the request is not accepted.

## Test plan

- Reset, then idle for 5 cycles: required response is req_ready = 1, upd_we = 0 and done = 0 throughout; all upd_* outputs are 0.
- Program idx = 8'd5, mask = all 1s, value = 144'h0: required response is 72 writes with upd_col = 5, upd_blk = 0..71 and upd_bits = 4'b0001 each; done at N+73; req_ready high at N+74.
- Program idx = 8'd255, mask = 144'h0: required response is upd_bits = 4'b1111 on all 72 writes. Next, delete idx = 255: required response is 72 writes with upd_bits = 4'b0000.
- Program with value[3:0] = 4'b1011, mask[3:0] = 4'b0110, all other mask bits 0:
  - block 0 (v = 11, m = 10): upd_bits = 4'b1100.
  - block 1 (v = 10, m = 01): upd_bits = 4'b0101.
  - blocks 2..71: upd_bits = 4'b1111.
- Hold req_valid high continuously with two distinct requests (idx 3, then idx 7): required response is the second acceptance at N+74 with no overlap of write bursts. Scoreboard: a behavioural 72 x 4 x 256 array model, after both bursts, produces a match vector equal to the ternary compare for random keys.
- Assert rst at cycle N+30 of a burst: required response is upd_we = 0 and req_ready = 1 from the next cycle, with no done pulse. A new request is then accepted and completes normally.

Source files
------------

// File: rtl/tcam_rule_writer.sv
// Turns one ternary rule into 72 sequential per-column writes, one per
// 2-bit-addressed sub-block of the SRAM-emulated TCAM array.
module tcam_rule_writer #(
    parameter int KEY_W     = 144,
    parameter int NUM_RULES = 256,
    parameter int IDX_W     = $clog2(NUM_RULES),
    parameter int BLK_W     = $clog2(KEY_W / 2)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [KEY_W-1:0] req_value,
    input  logic [KEY_W-1:0] req_mask,
    output logic             upd_we,
    output logic [BLK_W-1:0] upd_blk,
    output logic [IDX_W-1:0] upd_col,
    output logic [3:0]       upd_bits,
    output logic             done
);

    localparam int BLKS = KEY_W / 2;
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [KEY_W-1:0] val_sh, val_sh_nxt;
    logic [KEY_W-1:0] msk_sh, msk_sh_nxt;
    logic             op_q, op_nxt;
    logic             req_ready_nxt, upd_we_nxt, done_nxt;
    logic [BLK_W-1:0] upd_blk_nxt;
    logic [IDX_W-1:0] upd_col_nxt;
    logic [3:0]       upd_bits_nxt;

    // Entry a of a sub-block stores 1 when address a satisfies the cared bits.
    function automatic logic [3:0] enc(input logic [1:0] v, input logic [1:0] m,
                                       input logic del);
        logic [3:0] r;
        for (int a = 0; a < 4; a++)
            r[a] = !del && (((2'(a) ^ v) & m) == 2'b00);
        return r;
    endfunction

    always_comb begin
        state_nxt     = state;
        val_sh_nxt    = val_sh;
        msk_sh_nxt    = msk_sh;
        op_nxt        = op_q;
        req_ready_nxt = req_ready;
        upd_we_nxt    = 1'b0;
        done_nxt      = 1'b0;
        upd_blk_nxt   = upd_blk;
        upd_col_nxt   = upd_col;
        upd_bits_nxt  = upd_bits;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    state_nxt     = WRITE;
                    req_ready_nxt = 1'b0;
                    upd_we_nxt    = 1'b1;
                    upd_blk_nxt   = '0;
                    upd_col_nxt   = req_idx;
                    upd_bits_nxt  = enc(req_value[1:0], req_mask[1:0], req_op);
                    val_sh_nxt    = req_value >> 2;
                    msk_sh_nxt    = req_mask >> 2;
                    op_nxt        = req_op;
                end
            end
            WRITE: begin
                if (upd_blk == LAST_BLK) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    // Lowest two bits of the shifters always belong to the next block.
                    upd_we_nxt   = 1'b1;
                    upd_blk_nxt  = upd_blk + 1'b1;
                    upd_bits_nxt = enc(val_sh[1:0], msk_sh[1:0], op_q);
                    val_sh_nxt   = val_sh >> 2;
                    msk_sh_nxt   = msk_sh >> 2;
                end
            end
            DONE: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            val_sh    <= '0;
            msk_sh    <= '0;
            op_q      <= 1'b0;
            req_ready <= 1'b1;
            upd_we    <= 1'b0;
            upd_blk   <= '0;
            upd_col   <= '0;
            upd_bits  <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            val_sh    <= val_sh_nxt;
            msk_sh    <= msk_sh_nxt;
            op_q      <= op_nxt;
            req_ready <= req_ready_nxt;
            upd_we    <= upd_we_nxt;
            upd_blk   <= upd_blk_nxt;
            upd_col   <= upd_col_nxt;
            upd_bits  <= upd_bits_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_tcam_rule_writer.sv
// Scoreboard bench: requests push expected writes/done/ready windows; a negedge
// monitor checks them and replays writes into an array model for match checks.
module tb_tcam_rule_writer;

    localparam int KEY_W = 144;
    localparam int BLKS  = 72;
    localparam int NR    = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [7:0]   req_idx;
    logic [143:0] req_value;
    logic [143:0] req_mask;
    logic         upd_we;
    logic [6:0]   upd_blk;
    logic [7:0]   upd_col;
    logic [3:0]   upd_bits;
    logic         done;

    tcam_rule_writer dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_idx(req_idx),
        .req_value(req_value), .req_mask(req_mask),
        .upd_we(upd_we), .upd_blk(upd_blk), .upd_col(upd_col),
        .upd_bits(upd_bits), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         blk;
        int         col;
        logic [3:0] bits;
    } wr_t;

    wr_t  wq[$];
    int   dq[$];
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   mon_en = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    logic [255:0] mem [BLKS][4];
    bit           r_v [NR];
    logic [143:0] r_val [NR];
    logic [143:0] r_msk [NR];

    task automatic chk(input bit ok, input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Address a is stored as a match when every cared bit of a equals the value bit.
    function automatic logic [3:0] exp_bits(input logic [1:0] v, input logic [1:0] m);
        logic [3:0] r;
        for (int a = 0; a < 4; a++) begin
            r[a] = 1'b1;
            for (int j = 0; j < 2; j++)
                if (m[j] && (((a >> j) & 1) != int'(v[j]))) r[a] = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [143:0] rnd144();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic push_req(input int n, input bit op, input int idx,
                            input logic [143:0] v, input logic [143:0] m);
        wr_t w;
        for (int k = 0; k < BLKS; k++) begin
            w.cyc  = n + 1 + k;
            w.blk  = k;
            w.col  = idx;
            w.bits = op ? 4'b0000 : exp_bits(v[2*k +: 2], m[2*k +: 2]);
            wq.push_back(w);
        end
        dq.push_back(n + BLKS + 1);
        busy_lo = n + 1;
        busy_hi = n + BLKS + 1;
        r_v[idx]   = !op;
        r_val[idx] = v;
        r_msk[idx] = m;
    endtask

    // Drives a request and returns its acceptance cycle; req_valid is left high.
    task automatic issue(input bit op, input int idx, input logic [143:0] v,
                         input logic [143:0] m, output int n);
        req_op    = op;
        req_idx   = 8'(idx);
        req_value = v;
        req_mask  = m;
        req_valid = 1'b1;
        n = -1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (req_ready && !rst) begin
                n = cyc;
                push_req(n, op, idx, v, m);
                @(posedge clk);
                #1;
                break;
            end
        end
        if (n < 0) begin
            chk(1'b0, "accept_timeout", 256'(req_ready), 256'(1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_quiet();
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (wq.size() == 0 && dq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk(1'b0, "drain_timeout", 256'(wq.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            bit  exp_done;
            bit  exp_ready;
            wr_t e;
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                e = wq.pop_front();
                chk(1'b0, "missing_write", 256'(e.blk), 256'(e.cyc));
            end
            if (upd_we) begin
                if (wq.size() == 0 || wq[0].cyc != cyc) begin
                    chk(1'b0, "unexpected_write", 256'(upd_blk), 256'(cyc));
                end else begin
                    e = wq.pop_front();
                    chk(int'(upd_blk) == e.blk && int'(upd_col) == e.col && upd_bits === e.bits,
                        "write", {upd_blk, upd_col, upd_bits},
                        {7'(e.blk), 8'(e.col), e.bits});
                end
                if (int'(upd_blk) < BLKS)
                    for (int a = 0; a < 4; a++) mem[upd_blk][a][upd_col] = upd_bits[a];
            end
            exp_done = (dq.size() > 0 && dq[0] == cyc);
            chk(done === exp_done, "done", 256'(done), 256'(exp_done));
            if (exp_done) void'(dq.pop_front());
            exp_ready = !(cyc >= busy_lo && cyc <= busy_hi);
            chk(req_ready === exp_ready, "req_ready", 256'(req_ready), 256'(exp_ready));
        end
    end

    initial begin
        int n1, n2, n;
        logic [143:0] v, m, key;
        logic [255:0] got_mv, exp_mv;

        for (int b = 0; b < BLKS; b++)
            for (int a = 0; a < 4; a++) mem[b][a] = '0;
        for (int i = 0; i < NR; i++) begin
            r_v[i] = 1'b0; r_val[i] = '0; r_msk[i] = '0;
        end

        // Reset with a competing request: reset must win.
        rst = 1'b1; req_valid = 1'b1; req_op = 1'b0; req_idx = 8'd1;
        req_value = '0; req_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({req_ready, upd_we, done, upd_blk, upd_col, upd_bits} === {1'b1, 1'b0, 1'b0, 19'd0},
                "idle_reset_state", {req_ready, upd_we, done, upd_blk, upd_col, upd_bits},
                {1'b1, 1'b0, 1'b0, 19'd0});
        end
        @(posedge clk); #1;

        issue(1'b0, 5, '0, {KEY_W{1'b1}}, n);
        req_valid = 1'b0;
        wait_quiet();

        issue(1'b0, 255, rnd144(), '0, n);
        req_valid = 1'b0;
        wait_quiet();
        issue(1'b1, 255, rnd144(), rnd144(), n);
        req_valid = 1'b0;
        wait_quiet();

        v = rnd144(); v[3:0] = 4'b1011;
        m = '0;       m[3:0] = 4'b0110;
        issue(1'b0, 20, v, m, n);
        req_valid = 1'b0;
        wait_quiet();

        // Continuous valid: second acceptance exactly one full rule period later.
        issue(1'b0, 3, rnd144(), rnd144(), n1);
        issue(1'b0, 7, rnd144(), rnd144(), n2);
        req_valid = 1'b0;
        chk(n2 - n1 == BLKS + 2, "b2b_accept_gap", 256'(n2 - n1), 256'(BLKS + 2));
        wait_quiet();

        // Abort mid-burst, then reissue the same column.
        issue(1'b0, 9, rnd144(), rnd144(), n);
        req_valid = 1'b0;
        while (cyc < n + 30) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        wq.delete();
        dq.delete();
        busy_hi = cyc - 1;
        r_v[9] = 1'b0;
        @(negedge clk);
        chk(!upd_we && req_ready, "abort_state", {upd_we, req_ready}, 256'b01);
        @(posedge clk); #1;
        issue(1'b0, 9, rnd144(), rnd144(), n);
        req_valid = 1'b0;
        wait_quiet();

        for (int i = 0; i < 12; i++) begin
            m = rnd144() & rnd144();
            if ($urandom_range(0, 3) == 0) m = ~m;
            issue(1'($urandom_range(0, 4) == 0), int'($urandom_range(0, NR - 1)), rnd144(), m, n);
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
        end
        req_valid = 1'b0;
        wait_quiet();

        for (int t = 0; t < 40; t++) begin
            key = rnd144();
            if (t % 2 == 0) begin
                int c = int'($urandom_range(0, NR - 1));
                for (int s = 0; s < NR && !r_v[c]; s++) c = (c + 1) % NR;
                key = (r_val[c] & r_msk[c]) | (key & ~r_msk[c]);
            end
            for (int c = 0; c < NR; c++) begin
                got_mv[c] = 1'b1;
                for (int b = 0; b < BLKS; b++)
                    got_mv[c] = got_mv[c] & mem[b][key[2*b +: 2]][c];
                exp_mv[c] = r_v[c] && (((key ^ r_val[c]) & r_msk[c]) == '0);
            end
            chk(got_mv === exp_mv, "match_vector", got_mv, exp_mv);
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
